usb_dfu_flash_sequencer: RTL
============================

Name: usb_dfu_flash_sequencer

Overview:
- Upstream neighbour of the SPI flash bridge: turns decoded DFU_DNLOAD / DFU_UPLOAD requests plus the EP0 byte streams into the bridge's page-address / request / byte-handshake protocol.
- Tracks per-block progress and exposes busy/status/manifest signals to the DFU GETSTATUS logic.
- One block maps to one flash page: page = BASE_PAGE + block_num.

Parameters:
PAGE_SIZE, 256, bytes per flash page and per DFU transfer block; max accepted wLength
BASE_PAGE, 16'h0280, first flash page of the user image (region after the bootloader)
PAGE_LIMIT, 16'h0800, first page beyond the writable region (exclusive bound)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low (0 = reset)
dn_start  in  1  one-cycle pulse: DFU_DNLOAD decoded
up_start  in  1  one-cycle pulse: DFU_UPLOAD decoded
block_num  in  16  wValue, sampled on dn_start/up_start
req_len  in  16  wLength, sampled on dn_start/up_start
abort  in  1  one-cycle pulse: DFU_ABORT / bus reset
out_data  in  8  EP0 OUT byte
out_valid  in  1  EP0 OUT byte valid
out_ready  out  1  byte consumed this cycle
in_data  out  8  EP0 IN byte
in_put  out  1  EP0 IN byte valid this cycle
in_free  in  1  EP0 IN can accept a byte
address  out  16  flash page address to bridge
rd_request  out  1  to bridge
rd_data_free  out  1  to bridge
rd_data_put  in  1  from bridge
rd_data  in  8  from bridge
wr_request  out  1  to bridge
wr_busy  in  1  from bridge
wr_data_avail  out  1  to bridge
wr_data_get  in  1  from bridge
wr_data  out  8  to bridge
busy  out  1  high while a download block is not yet committed (dfuDNBUSY)
status  out  4  DFU bStatus: 0 OK, 4'h8 errADDRESS, 4'hE errUNKNOWN
done  out  1  one-cycle pulse when a block or upload completes
manifest  out  1  one-cycle pulse on zero-length DNLOAD

Behaviour:
- Reset (reset=0 at posedge): state IDLE; address=0, byte count=0, rd_request=wr_request=busy=done=manifest=0, status=0, in_put=0, in_data=0.
- Registers: state, address, len (16b), cnt (16b), seen_busy. cnt saturates at len; never wraps.
- IDLE:
  - dn_start with req_len=0 -> manifest pulse next cycle, stay IDLE.
  - dn_start with req_len>PAGE_SIZE, or BASE_PAGE+block_num >= PAGE_LIMIT (17-bit sum, no wrap) -> status=8 (len error uses 4'hE), ERROR.
  - Otherwise latch address/len, cnt=0, seen_busy=0, status=0, busy=1 -> DN_DATA.
  - up_start: same address check -> UP_DATA, with len=min(req_len, PAGE_SIZE); req_len=0 -> done pulse, stay IDLE.
  - dn_start wins if both strobes coincide.
- DN_DATA: wr_request=1.
  - wr_data=out_data; wr_data_avail = out_valid && cnt<len; out_ready = wr_data_get (combinational passthrough, no buffering).
  - Each wr_data_get increments cnt. wr_busy high sets seen_busy.
  - When cnt==len (registered), drop wr_request -> DN_WAIT.
- DN_WAIT: wr_request=0. When seen_busy && !wr_busy -> done pulse, busy=0, IDLE. Sets seen_busy if wr_busy rises late; the bridge registers its state, so wr_busy lags wr_request by >=1 cycle.
- UP_DATA: rd_request=1, rd_data_free = in_free && cnt<len.
  - Each rd_data_put: in_data<=rd_data, in_put<=1 (1-cycle register), cnt++.
  - cnt==len -> rd_request=0, done pulse, IDLE. Bridge over-fetch after cnt==len is discarded (in_put stays 0).
- ERROR: holds status; a dn_start/up_start re-evaluates as from IDLE (status cleared on acceptance). abort -> status=0, IDLE.
- abort:
  - In UP_DATA -> rd_request=0, IDLE, no done.
  - In DN_DATA -> wr_request=0, go DN_WAIT; a flash program in progress is never cut short. cnt is frozen, so bytes already cached are programmed.
- dn_start/up_start outside IDLE/ERROR are ignored.
- address is stable from acceptance until return to IDLE; the bridge samples it throughout.

Decomposition:
- Shared package usb_dfu_pkg: DFU bStatus codes (OK, errADDRESS, errUNKNOWN), sequencer state encoding (IDLE, DN_DATA, DN_WAIT, UP_DATA, ERROR), BASE_PAGE/PAGE_LIMIT defaults.
- No sub-module; the range check is a small function in the package.

Test Plan:
- dn_start block_num=0, req_len=256, 256 bytes 0x00..0xFF with out_valid continuous; bridge model sinks -> address=0x0280, exactly 256 wr_data_get, wr_request falls after byte 256, busy falls and done pulses after model wr_busy falls, status=0.
- dn_start req_len=100 with out_valid toggling every other cycle -> cnt=100, wr_data_avail never high at cnt=100, block committed, no extra byte consumed.
- dn_start block_num=16'h0580 (page 0x0800) -> status=8, ERROR, no wr_request; then abort -> status=0, IDLE.
- up_start block_num=3, req_len=64, in_free low every 4th cycle, model streams page 0x0283 -> 64 in_put pulses with matching data, rd_request drops, a 65th bridge byte is not forwarded.
- abort mid-download after 40 bytes -> wr_request drops, state waits for wr_busy low, no done; then dn_start req_len=0 -> single manifest pulse.
- reset=0 asserted in DN_DATA -> next cycle all outputs at reset values; wr_request=0.

Source files
------------

// File: rtl/usb_dfu_pkg.sv
// Shared DFU definitions: bStatus codes, sequencer state encoding, flash region bounds
// and the block-to-page range check.
package usb_dfu_pkg;

   localparam logic [3:0] STATUS_OK          = 4'h0;
   localparam logic [3:0] STATUS_ERR_ADDRESS = 4'h8;
   localparam logic [3:0] STATUS_ERR_UNKNOWN = 4'hE;

   localparam int          DEFAULT_PAGE_SIZE  = 256;
   localparam logic [15:0] DEFAULT_BASE_PAGE  = 16'h0280;
   localparam logic [15:0] DEFAULT_PAGE_LIMIT = 16'h0800;

   typedef enum logic [2:0] {
      IDLE,
      DN_DATA,
      DN_WAIT,
      UP_DATA,
      ERROR
   } seq_state_t;

   // The sum is carried in 17 bits so a huge block number cannot wrap back into range.
   function automatic logic page_in_range(input logic [15:0] base_page,
                                          input logic [15:0] blk,
                                          input logic [15:0] page_limit);
      logic [16:0] page;
      page = {1'b0, base_page} + {1'b0, blk};
      return page < {1'b0, page_limit};
   endfunction

endpackage

// File: rtl/usb_dfu_flash_sequencer.sv
// Maps DFU DNLOAD/UPLOAD blocks onto SPI flash bridge page transfers, one block per page.
// Byte handshakes are combinational passthroughs; in_put is one register behind rd_data_put.
module usb_dfu_flash_sequencer
   import usb_dfu_pkg::*;
#(
   parameter int          PAGE_SIZE  = DEFAULT_PAGE_SIZE,
   parameter logic [15:0] BASE_PAGE  = DEFAULT_BASE_PAGE,
   parameter logic [15:0] PAGE_LIMIT = DEFAULT_PAGE_LIMIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dn_start,
   input  logic        up_start,
   input  logic [15:0] block_num,
   input  logic [15:0] req_len,
   input  logic        abort,
   input  logic [7:0]  out_data,
   input  logic        out_valid,
   output logic        out_ready,
   output logic [7:0]  in_data,
   output logic        in_put,
   input  logic        in_free,
   output logic [15:0] address,
   output logic        rd_request,
   output logic        rd_data_free,
   input  logic        rd_data_put,
   input  logic [7:0]  rd_data,
   output logic        wr_request,
   input  logic        wr_busy,
   output logic        wr_data_avail,
   input  logic        wr_data_get,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic [3:0]  status,
   output logic        done,
   output logic        manifest
);

   localparam logic [15:0] PAGE_LEN = 16'(PAGE_SIZE);

   seq_state_t  state;
   logic [15:0] len;
   logic [15:0] cnt;
   logic        seen_busy;
   logic        aborted;

   logic        room;
   logic        start_ok;
   logic [15:0] start_page;

   assign room       = cnt < len;
   assign start_ok   = page_in_range(BASE_PAGE, block_num, PAGE_LIMIT);
   assign start_page = BASE_PAGE + block_num;

   assign wr_data       = out_data;
   assign wr_data_avail = (state == DN_DATA) && out_valid && room;
   assign out_ready     = (state == DN_DATA) && wr_data_get && room;
   assign rd_data_free  = (state == UP_DATA) && in_free && room;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         address    <= '0;
         len        <= '0;
         cnt        <= '0;
         seen_busy  <= 1'b0;
         aborted    <= 1'b0;
         rd_request <= 1'b0;
         wr_request <= 1'b0;
         busy       <= 1'b0;
         status     <= STATUS_OK;
         done       <= 1'b0;
         manifest   <= 1'b0;
         in_put     <= 1'b0;
         in_data    <= '0;
      end else begin
         done     <= 1'b0;
         manifest <= 1'b0;
         in_put   <= 1'b0;
         case (state)
            IDLE, ERROR: begin
               if (abort && state == ERROR) begin
                  status <= STATUS_OK;
                  state  <= IDLE;
               end else if (dn_start) begin
                  if (req_len == 16'd0) begin
                     manifest <= 1'b1;
                     status   <= STATUS_OK;
                     state    <= IDLE;
                  end else if (!start_ok) begin
                     status <= STATUS_ERR_ADDRESS;
                     state  <= ERROR;
                  end else if (req_len > PAGE_LEN) begin
                     status <= STATUS_ERR_UNKNOWN;
                     state  <= ERROR;
                  end else begin
                     address    <= start_page;
                     len        <= req_len;
                     cnt        <= '0;
                     seen_busy  <= 1'b0;
                     aborted    <= 1'b0;
                     status     <= STATUS_OK;
                     busy       <= 1'b1;
                     wr_request <= 1'b1;
                     state      <= DN_DATA;
                  end
               end else if (up_start) begin
                  if (!start_ok) begin
                     status <= STATUS_ERR_ADDRESS;
                     state  <= ERROR;
                  end else if (req_len == 16'd0) begin
                     done   <= 1'b1;
                     status <= STATUS_OK;
                     state  <= IDLE;
                  end else begin
                     address    <= start_page;
                     len        <= (req_len > PAGE_LEN) ? PAGE_LEN : req_len;
                     cnt        <= '0;
                     status     <= STATUS_OK;
                     rd_request <= 1'b1;
                     state      <= UP_DATA;
                  end
               end
            end
            DN_DATA: begin
               if (wr_busy) seen_busy <= 1'b1;
               if (out_ready) cnt <= cnt + 16'd1;
               // Abort only stops new bytes; whatever the bridge already holds still gets programmed.
               if (abort) begin
                  wr_request <= 1'b0;
                  aborted    <= 1'b1;
                  state      <= DN_WAIT;
               end else if (cnt == len) begin
                  wr_request <= 1'b0;
                  state      <= DN_WAIT;
               end
            end
            DN_WAIT: begin
               if (wr_busy) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  busy  <= 1'b0;
                  done  <= !aborted;
                  state <= IDLE;
               end
            end
            UP_DATA: begin
               if (abort) begin
                  rd_request <= 1'b0;
                  state      <= IDLE;
               end else if (cnt == len) begin
                  rd_request <= 1'b0;
                  done       <= 1'b1;
                  state      <= IDLE;
               end else if (rd_data_put) begin
                  in_data <= rd_data;
                  in_put  <= 1'b1;
                  cnt     <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
